// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// Optional build macro RF_DUMP_INDEX_EN adds a per-register index header byte.
package rf_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DW_DEFAULT     = 32;
  localparam int BYTES_PER_WORD = DW_DEFAULT / 8;

`ifdef RF_DUMP_INDEX_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  // Header byte is {3'b0, index[4:0]}.
  localparam logic [7:0] HDR_IDX_MASK = 8'h1F;

  function automatic logic [7:0] hdr_byte(input logic [7:0] idx);
    return idx & HDR_IDX_MASK;
  endfunction

endpackage

// File: rtl/rf_dump_reader_if.sv
// Byte stream from the dump reader to a UART transmitter or test sink.
interface rf_dump_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/rf_dump_shifter.sv
// Snapshot/shift register that serialises one register word little-endian.
// With RF_DUMP_INDEX_EN the index header byte is emitted before the data bytes.
module rf_dump_shifter
  import rf_dump_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [DW-1:0] load_data,
`ifdef RF_DUMP_INDEX_EN
  input  logic [7:0]    hdr,
`endif
  output logic [7:0]    tx_data,
  output logic          last_byte
);

  localparam int NBYTES = DW / 8 + HDR_BYTES;
  localparam int CW     = $clog2(NBYTES + 1);

  logic [DW-1:0] word;
  logic [CW-1:0] byte_cnt;

  // word always holds the bytes still to be emitted, lowest byte next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
    end else if (load) begin
      byte_cnt <= '0;
`ifdef RF_DUMP_INDEX_EN
      word     <= load_data;
      tx_data  <= hdr_byte(hdr);
`else
      word     <= load_data >> 8;
      tx_data  <= load_data[7:0];
`endif
    end else if (advance && !last_byte) begin
      byte_cnt <= byte_cnt + CW'(1);
      tx_data  <= word[7:0];
      word     <= word >> 8;
    end
  end

  assign last_byte = (byte_cnt == CW'(NBYTES - 1));

endmodule

// File: rtl/rf_dump_reader.sv
// Debug engine that walks register indices 0..NREGS-1 and streams each word out as bytes.
// Define RF_DUMP_INDEX_EN to prefix every register with its index byte.
module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] reg_sel,
  input  logic [DW-1:0] reg_data,
  rf_dump_reader_if.master tx
);

  state_t state;
  logic   last_byte;
  logic   tx_fire;

  assign tx_fire = tx.tx_valid && tx.tx_ready;

  rf_dump_shifter #(.DW(DW)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_LATCH),
    .advance   (tx_fire),
    .load_data (reg_data),
`ifdef RF_DUMP_INDEX_EN
    .hdr       (8'(reg_sel)),
`endif
    .tx_data   (tx.tx_data),
    .last_byte (last_byte)
  );

  // NOTE: async reset sits in the sensitivity list; all state here uses <= so every
  // branch sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      reg_sel     <= '0;
      tx.tx_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            reg_sel <= '0;
            busy    <= 1'b1;
            state   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          tx.tx_valid <= 1'b1;
          state       <= ST_SEND;
        end
        ST_SEND: begin
          // Intermediate bytes advance inside the shifter; only the last one ends the word.
          if (tx_fire && last_byte) begin
            tx.tx_valid <= 1'b0;
            if (reg_sel == AW'(NREGS - 1)) begin
              state <= ST_DONE;
            end else begin
              reg_sel <= reg_sel + AW'(1);
              state   <= ST_LATCH;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader; expectations follow RF_DUMP_INDEX_EN when defined.
module tb_rf_dump_reader;
  import rf_dump_pkg::*;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;
`ifdef RF_DUMP_INDEX_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB       = BYTES_PER_WORD + HDR;
  localparam int TOTAL    = NREGS * NB;
  localparam int DONE_CYC = NREGS * (NB + 1) + 2;
  localparam int ABORT_AT = 12 * NB + HDR + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] reg_sel;
  logic [DW-1:0] reg_data;
  logic [DW-1:0] rf [NREGS];

  int checks   = 0;
  int failures = 0;

  rf_dump_reader_if tx_bus ();

  rf_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .reg_sel  (reg_sel),
    .reg_data (reg_data),
    .tx       (tx_bus.master)
  );

  always #5 clk = ~clk;

  assign reg_data = (reg_sel == '0) ? '0 : rf[reg_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n, input bit r5_alt);
    int          r;
    int          k;
    logic [31:0] w;
    r = n / NB;
    k = n % NB;
    w = (r == 0) ? 32'h0 : (r5_alt && r == 5) ? 32'hAABB_CCDD : 32'h1000_0000 + r;
    if (HDR == 1) begin
      if (k == 0) return 8'(r);
      k--;
    end
    return w[8*k +: 8];
  endfunction

  task automatic run_dump(input string tag, input bit toggle, input bit poke_r5,
                          input bit repulse, input bit want_cyc);
    logic [7:0] got[$];
    logic [7:0] held_data;
    int         cyc;
    int         done_cnt;
    int         done_cyc;
    bit         held;
    bit         poked;
    done_cnt = 0;
    done_cyc = -1;
    held     = 1'b0;
    poked    = 1'b0;
    held_data = '0;
    @(negedge clk);
    start = 1'b1;
    tx_bus.tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    cyc = 1;
    while (cyc < 2000 && !(done_cyc >= 0 && cyc > done_cyc + 3)) begin
      tx_bus.tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      start = repulse && (cyc == 10 || cyc == 50);
      if (held) begin
        check({tag, " stall_valid"}, tx_bus.tx_valid, 1);
        check({tag, " stall_data"}, tx_bus.tx_data, held_data);
      end
      if (poke_r5 && !poked && tx_bus.tx_valid && reg_sel == 5) begin
        rf[5] = 32'h1111_1111;
        poked = 1'b1;
      end
      if (tx_bus.tx_valid && tx_bus.tx_ready) got.push_back(tx_bus.tx_data);
      held      = tx_bus.tx_valid && !tx_bus.tx_ready;
      held_data = tx_bus.tx_data;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) check({tag, " busy_after_done"}, busy, 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tx_bus.tx_ready = 1'b1;
    check({tag, " done_seen_in_budget"}, done_cyc >= 0, 1);
    check({tag, " done_pulses"}, done_cnt, 1);
    if (want_cyc) check({tag, " done_cycle"}, done_cyc, DONE_CYC);
    if (poke_r5) check({tag, " r5_written"}, poked, 1);
    check({tag, " byte_count"}, got.size(), TOTAL);
    for (int n = 0; n < got.size() && n < TOTAL; n++)
      check($sformatf("%s byte%0d", tag, n), got[n], exp_byte(n, poke_r5));
  endtask

  task automatic abort_dump();
    int cnt;
    int cyc;
    cnt = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    tx_bus.tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cnt < ABORT_AT && cyc < 1000) begin
      if (tx_bus.tx_valid && tx_bus.tx_ready) cnt++;
      @(negedge clk);
      cyc++;
    end
    check("abort bytes_before_reset", cnt, ABORT_AT);
    check("abort reg_sel_before_reset", reg_sel, 12);
    check("abort valid_before_reset", tx_bus.tx_valid, 1);
    rst = 1'b1;
    #1;
    check("abort rst_busy", busy, 0);
    check("abort rst_done", done, 0);
    check("abort rst_reg_sel", reg_sel, 0);
    check("abort rst_tx_valid", tx_bus.tx_valid, 0);
    check("abort rst_tx_data", tx_bus.tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort idle_no_done", done, 0);
    end
    check("abort idle_busy", busy, 0);
    check("abort idle_tx_valid", tx_bus.tx_valid, 0);
  endtask

  initial begin
    tx_bus.tx_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000_0000 + i;
    #2;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset reg_sel", reg_sel, 0);
    check("reset tx_valid", tx_bus.tx_valid, 0);
    check("reset tx_data", tx_bus.tx_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);
    check("idle tx_valid", tx_bus.tx_valid, 0);

    run_dump("plain", 1'b0, 1'b0, 1'b0, 1'b1);
    run_dump("toggle", 1'b1, 1'b0, 1'b0, 1'b0);

    rf[5] = 32'hAABB_CCDD;
    run_dump("r5_write", 1'b0, 1'b1, 1'b0, 1'b1);
    rf[5] = 32'h1000_0005;

    run_dump("restart", 1'b0, 1'b0, 1'b1, 1'b1);

    abort_dump();
    run_dump("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
